flop_bist: RTL and testbench

- Synthesizable built-in self-test driver/checker for a WIDTH-bit bank of clock-enable, async-preset D flops (one flop per bit, common CE and preset).
- Drives D/CE/PRE into the bank, reads Q back, and compares it against an internal behavioural model of the flop.
- Sits beside the CPU register storage. It is used at power-up or on demand to prove the storage primitives before the CPU starts.

---
 rtl/flop_bist_pkg.sv | 34 +++
 rtl/flop_bist_if.sv | 28 ++
 rtl/flop_bist_vector_rom.sv | 18 +
 rtl/flop_bist.sv | 148 ++++++++++++++
 tb/tb_flop_bist.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/flop_bist_pkg.sv
// Shared types, vector table and reference model for the flop bank self-test.
package flop_bist_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SETTLE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int NUM_VECTORS = 8;
    localparam int VEC_D_W     = 8;
    // Model arithmetic is done at this width and truncated to the bank width,
    // so banks up to 64 bits are supported.
    localparam int MODEL_W     = 64;

    // Entry k sits at index k (entry 0 is the rightmost literal).
    localparam logic [NUM_VECTORS-1:0][VEC_D_W-1:0] VEC_D = {
        8'hC3, 8'h00, 8'h5A, 8'h5A, 8'h3C, 8'h00, 8'h00, 8'hA5
    };
    localparam logic [NUM_VECTORS-1:0] VEC_CE  = 8'b0010_1111;
    localparam logic [NUM_VECTORS-1:0] VEC_PRE = 8'b1000_1100;

    // Behaviour of one CE/async-preset D flop bank after a vector is applied.
    function automatic logic [MODEL_W-1:0] model_next(
        input logic [MODEL_W-1:0] cur,
        input logic [MODEL_W-1:0] d,
        input logic               ce,
        input logic               pre
    );
        return pre ? '1 : (ce ? d : cur);
    endfunction

endpackage

// File: rtl/flop_bist_if.sv
// Handshake and bank-side signals between the BIST engine and its environment.
interface flop_bist_if #(
    parameter int WIDTH = 8
);
    logic             input_start;
    logic [WIDTH-1:0] input_q;
    logic [WIDTH-1:0] output_d;
    logic             output_clock_enable;
    logic             output_preset;
    logic             output_busy;
    logic             output_done;
    logic             output_pass;
    logic [2:0]       output_fail_index;

    // BIST engine side.
    modport master (
        input  input_start, input_q,
        output output_d, output_clock_enable, output_preset,
        output output_busy, output_done, output_pass, output_fail_index
    );

    // Controller and bank side.
    modport slave (
        output input_start, input_q,
        input  output_d, output_clock_enable, output_preset,
        input  output_busy, output_done, output_pass, output_fail_index
    );
endinterface

// File: rtl/flop_bist_vector_rom.sv
// Combinational lookup of one test vector {D, CE, PRE} by index.
module flop_bist_vector_rom
    import flop_bist_pkg::*;
(
    input  logic [2:0]         idx,
    output logic [VEC_D_W-1:0] d,
    output logic               ce,
    output logic               pre
);

    // Pure table read; no state.
    always_comb begin
        d   = VEC_D[idx];
        ce  = VEC_CE[idx];
        pre = VEC_PRE[idx];
    end

endmodule

// File: rtl/flop_bist.sv
// BIST driver/checker for a WIDTH-bit CE/async-preset flop bank: walks the
// fixed vector table, tracks the expected bank contents, stops on first miss.
module flop_bist
    import flop_bist_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int SETTLE_CYCLES = 1
) (
    input logic         clock,
    input logic         reset_n,
    flop_bist_if.master bus
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic             exp_vld_q, exp_vld_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic             ce_q, ce_d;
    logic             pre_q, pre_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [2:0]       fidx_q, fidx_d;

    logic [2:0]         rom_idx;
    logic [VEC_D_W-1:0] rom_d;
    logic               rom_ce;
    logic               rom_pre;
    logic               match;
    logic               settle_last;

    // A start always drives vector 0; an advance from SETTLE drives the next.
    assign rom_idx = (state_q == SETTLE) ? idx_q + 3'd1 : 3'd0;

    flop_bist_vector_rom u_rom (
        .idx (rom_idx),
        .d   (rom_d),
        .ce  (rom_ce),
        .pre (rom_pre)
    );

    assign match       = exp_vld_q && (bus.input_q == exp_q);
    assign settle_last = (cnt_q <= CW'(1));

    // Next-state, drive and result logic; everything holds unless changed.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        exp_d     = exp_q;
        exp_vld_d = exp_vld_q;
        d_d       = d_q;
        ce_d      = ce_q;
        pre_d     = pre_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        fidx_d    = fidx_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.input_start) begin
                    state_d   = CAPTURE;
                    idx_d     = 3'd0;
                    d_d       = WIDTH'(rom_d);
                    ce_d      = rom_ce;
                    pre_d     = rom_pre;
                    exp_d     = WIDTH'(model_next(MODEL_W'(exp_q), MODEL_W'(rom_d), rom_ce, rom_pre));
                    exp_vld_d = 1'b1;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                    fidx_d    = 3'd0;
                end
            end
            CAPTURE: begin
                // The bank captures on the edge that leaves this state.
                state_d = SETTLE;
                cnt_d   = CW'(SETTLE_CYCLES);
            end
            SETTLE: begin
                if (!settle_last) begin
                    cnt_d = cnt_q - CW'(1);
                end else if (match && idx_q != 3'(NUM_VECTORS - 1)) begin
                    state_d = CAPTURE;
                    idx_d   = rom_idx;
                    d_d     = WIDTH'(rom_d);
                    ce_d    = rom_ce;
                    pre_d   = rom_pre;
                    exp_d   = WIDTH'(model_next(MODEL_W'(exp_q), MODEL_W'(rom_d), rom_ce, rom_pre));
                end else begin
                    // Last vector matched, or first miss: report and release preset.
                    state_d = DONE;
                    pre_d   = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = match;
                    fidx_d  = match ? 3'd0 : idx_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything so an aborted run leaves no preset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            exp_vld_q <= 1'b0;
            d_q       <= '0;
            ce_q      <= 1'b0;
            pre_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            fidx_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            exp_q     <= exp_d;
            exp_vld_q <= exp_vld_d;
            d_q       <= d_d;
            ce_q      <= ce_d;
            pre_q     <= pre_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            fidx_q    <= fidx_d;
        end
    end

    assign bus.output_d            = d_q;
    assign bus.output_clock_enable = ce_q;
    assign bus.output_preset       = pre_q;
    assign bus.output_busy         = busy_q;
    assign bus.output_done         = done_q;
    assign bus.output_pass         = pass_q;
    assign bus.output_fail_index   = fidx_q;

endmodule

// File: tb/tb_flop_bist.sv
// Bench for flop_bist: a behavioural flop bank with selectable faults, and a
// vector-level predictor of pass/fail index and completion edge.
module tb_flop_bist;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    int   mode    = 0;   // 0 good, 1 bit3 stuck-0, 2 ignores CE, 3 sync preset gated by CE
    int   errors  = 0;
    int   checks  = 0;

    logic [7:0] bank_a;
    logic [7:0] bank_s;

    flop_bist_if #(.WIDTH(8)) bus ();

    flop_bist #(.WIDTH(8), .SETTLE_CYCLES(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    // Bank with asynchronous preset (mode 2 loads regardless of CE).
    always @(posedge clock or posedge bus.output_preset) begin
        if (bus.output_preset) bank_a <= 8'hFF;
        else if (bus.output_clock_enable || mode == 2) bank_a <= bus.output_d;
    end

    // Faulty bank: preset only on a clock edge and only with CE.
    always @(posedge clock) begin
        if (bus.output_clock_enable) bank_s <= bus.output_preset ? 8'hFF : bus.output_d;
    end

    assign bus.input_q = (mode == 3 ? bank_s : bank_a) & (mode == 1 ? 8'hF7 : 8'hFF);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Vector table as a plain lookup: {D, CE, PRE}.
    function automatic logic [9:0] tvec(input int k);
        case (k)
            0: return {8'hA5, 1'b1, 1'b0};
            1: return {8'h00, 1'b1, 1'b0};
            2: return {8'h00, 1'b1, 1'b1};
            3: return {8'h3C, 1'b1, 1'b1};
            4: return {8'h5A, 1'b0, 1'b0};
            5: return {8'h5A, 1'b1, 1'b0};
            6: return {8'h00, 1'b0, 1'b0};
            default: return {8'hC3, 1'b0, 1'b1};
        endcase
    endfunction

    // Walk the table: what an ideal flop should hold vs. what the chosen bank holds.
    function automatic void predict(input int m, output logic p, output int fi);
        logic [7:0] e, b, d;
        logic       ce, pre, stop;
        logic [9:0] v;
        e = 8'h00; b = 8'h00; p = 1'b1; fi = 0; stop = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!stop) begin
                v = tvec(k);
                d = v[9:2]; ce = v[1]; pre = v[0];
                e = pre ? 8'hFF : (ce ? d : e);
                case (m)
                    2:       b = pre ? 8'hFF : d;
                    3:       b = ce ? (pre ? 8'hFF : d) : b;
                    default: b = pre ? 8'hFF : (ce ? d : b);
                endcase
                if (((m == 1) ? (b & 8'hF7) : b) != e) begin
                    p = 1'b0; fi = k; stop = 1'b1;
                end
            end
        end
    endfunction

    function automatic logic [31:0] all_out();
        return 32'({bus.output_d, bus.output_clock_enable, bus.output_preset,
                    bus.output_busy, bus.output_done, bus.output_pass, bus.output_fail_index});
    endfunction

    // One run from a start pulse; optional extra start pulse at edge pulse_at.
    task automatic run(input int m, input int pulse_at, input string tag);
        logic p;
        int   fi, dedge;
        mode = m;
        predict(m, p, fi);
        dedge = 2 * ((p ? 7 : fi) + 1);
        bus.input_start = 1'b1;
        tick();
        bus.input_start = 1'b0;
        chk({tag, "_start_busy"}, 32'({bus.output_busy, bus.output_done}), 32'(2'b10));
        for (int n = 1; n <= dedge; n++) begin
            bus.input_start = (n == pulse_at);
            tick();
            chk({tag, "_busy_done"}, 32'({bus.output_busy, bus.output_done}),
                (n < dedge) ? 32'(2'b10) : 32'(2'b01));
        end
        bus.input_start = 1'b0;
        chk({tag, "_pass"}, 32'(bus.output_pass), 32'(p));
        chk({tag, "_fidx"}, 32'(bus.output_fail_index), 32'(fi));
        chk({tag, "_preset"}, 32'(bus.output_preset), 32'(0));
    endtask

    initial begin
        bus.input_start = 1'b0;

        // Reset state, then idle without start.
        tick();
        chk("reset_outputs", all_out(), 32'(0));
        reset_n = 1'b1;
        tick(); tick();
        chk("idle_no_start", all_out(), 32'(0));

        // Directed fault cases.
        run(0, -1, "good");
        run(1, -1, "stuck3");
        run(2, -1, "no_ce");
        run(3, -1, "sync_pre");

        // Mid-run start pulse is ignored.
        run(0, 8, "start_mid");

        // Start held high through DONE restarts on the following edge.
        mode = 0;
        bus.input_start = 1'b1;
        for (int n = 0; n <= 16; n++) tick();
        chk("hold_done1", 32'({bus.output_done, bus.output_pass}), 32'(2'b11));
        tick();
        chk("hold_restart", 32'({bus.output_busy, bus.output_done}), 32'(2'b10));
        for (int n = 0; n < 15; n++) tick();
        chk("hold_not_yet", 32'(bus.output_done), 32'(0));
        tick();
        bus.input_start = 1'b0;
        chk("hold_done2", 32'({bus.output_done, bus.output_pass}), 32'(2'b11));

        // Reset mid-run aborts without a result.
        bus.input_start = 1'b1;
        tick();
        bus.input_start = 1'b0;
        for (int n = 0; n < 4; n++) tick();
        @(posedge clock);
        #1 reset_n = 1'b0;
        #1 chk("abort_async_zero", all_out(), 32'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("abort_stays_idle", all_out(), 32'(0));
        end
        run(0, -1, "after_reset");

        // Randomized runs across fault modes with stray start pulses.
        for (int r = 0; r < 10; r++) begin
            int gap;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
            run(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
